// File: rtl/custom_clock_phase_meter.sv
`default_nettype none
// ============================================================================
// Module      : custom_clock_phase_meter
// Description : Measures high/low phase lengths of sig_in in clk_in cycles,
//               flags complete periods, lock on repeated periods, and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_clock_phase_meter #(
    parameter int CYCLE_WIDTH = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sig_in,
    output logic [CYCLE_WIDTH-1:0] high_phase_cycles,
    output logic [CYCLE_WIDTH-1:0] low_phase_cycles,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   timeout
);

    localparam int c_match_w = $clog2(LOCK_COUNT + 1);
    localparam logic [c_match_w-1:0]   c_lock_target = c_match_w'(LOCK_COUNT);
    localparam logic [CYCLE_WIDTH-1:0] c_count_one   = CYCLE_WIDTH'(1);
    localparam logic [CYCLE_WIDTH-1:0] c_count_max   = {CYCLE_WIDTH{1'b1}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_meas = 2'd2;

    logic                   w_s;
    logic                   r_s_prev;
    logic [1:0]             r_state;
    logic [CYCLE_WIDTH-1:0] r_count;
    logic [CYCLE_WIDTH-1:0] r_high_phase;
    logic [CYCLE_WIDTH-1:0] r_low_phase;
    logic [CYCLE_WIDTH-1:0] r_prev_high;
    logic [CYCLE_WIDTH-1:0] r_prev_low;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_timeout;
    logic                   r_got_high;
    logic                   r_have_prev;
    logic [c_match_w-1:0]   r_match;

    logic                   w_edge;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_sat;
    logic [CYCLE_WIDTH-1:0] w_count_inc;
    logic                   w_pair_eq;
    logic [c_match_w-1:0]   w_match_next;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk_in) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_s = sig_in;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s_prev <= 1'b0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    assign w_edge      = w_s ^ r_s_prev;
    assign w_rise      = w_edge & w_s;
    assign w_fall      = w_edge & ~w_s;
    assign w_sat       = (r_count == c_count_max);
    assign w_count_inc = w_sat ? r_count : r_count + 1'b1;

    // New period is (last captured high, count ending this low phase)
    assign w_pair_eq    = r_have_prev && (r_high_phase == r_prev_high) && (r_count == r_prev_low);
    assign w_match_next = !w_pair_eq ? '0 :
                          (r_match == c_lock_target) ? r_match : r_match + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_count        <= c_count_one;
            r_high_phase   <= '0;
            r_low_phase    <= '0;
            r_prev_high    <= '0;
            r_prev_low     <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_got_high     <= 1'b0;
            r_have_prev    <= 1'b0;
            r_match        <= '0;
        end else if (!enable) begin
            // Measurement results are kept; all tracking state restarts
            r_state        <= c_st_idle;
            r_count        <= c_count_one;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_got_high     <= 1'b0;
            r_have_prev    <= 1'b0;
            r_match        <= '0;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_count <= c_count_one;
                    r_state <= c_st_arm;
                end
                c_st_arm: begin
                    r_count <= w_edge ? c_count_one : w_count_inc;
                    if (w_edge) begin
                        r_state <= c_st_meas;
                    end
                end
                c_st_meas: begin
                    r_count <= w_edge ? c_count_one : w_count_inc;
                    if (w_fall) begin
                        r_high_phase <= r_count;
                        r_got_high   <= 1'b1;
                    end
                    if (w_rise) begin
                        r_low_phase <= r_count;
                        if (r_got_high) begin
                            r_period_valid <= 1'b1;
                            r_match        <= w_match_next;
                            r_locked       <= (w_match_next == c_lock_target);
                            r_prev_high    <= r_high_phase;
                            r_prev_low     <= r_count;
                            r_have_prev    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
            // Saturation overrides any lock update made in the same cycle
            if (r_state != c_st_idle && w_sat) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
                r_match   <= '0;
            end
        end
    end

    assign high_phase_cycles = r_high_phase;
    assign low_phase_cycles  = r_low_phase;
    assign period_valid      = r_period_valid;
    assign locked            = r_locked;
    assign timeout           = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_custom_clock_phase_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_custom_clock_phase_meter
// Description : Scoreboard bench for custom_clock_phase_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_custom_clock_phase_meter;

    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sig_in;
    logic        en_t;
    logic        sig_t;
    logic [15:0] hpc;
    logic [15:0] lpc;
    logic        pv;
    logic        lk;
    logic        to;
    logic [3:0]  hpc_t;
    logic [3:0]  lpc_t;
    logic        pv_t;
    logic        lk_t;
    logic        to_t;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int h;
        int l;
        bit lk;
        int gap;
    } exp_t;
    exp_t sb[$];

    int m_prev_h;
    int m_prev_l;
    int m_match;
    bit m_have_prev;
    bit m_first;

    custom_clock_phase_meter #(.CYCLE_WIDTH(16), .SYNC_STAGES(2), .LOCK_COUNT(LOCK)) dut (
        .clk_in(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
        .high_phase_cycles(hpc), .low_phase_cycles(lpc),
        .period_valid(pv), .locked(lk), .timeout(to)
    );

    custom_clock_phase_meter #(.CYCLE_WIDTH(4), .SYNC_STAGES(2), .LOCK_COUNT(LOCK)) dut_t (
        .clk_in(clk), .rst(rst), .enable(en_t), .sig_in(sig_t),
        .high_phase_cycles(hpc_t), .low_phase_cycles(lpc_t),
        .period_valid(pv_t), .locked(lk_t), .timeout(to_t)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic level, input int n);
        sig_in = level;
        tick(n);
    endtask

    // Reference lock model and scoreboard push for one complete period
    task automatic expect_period(input int h, input int l);
        exp_t e;
        bit   eq;
        eq = m_have_prev && (h == m_prev_h) && (l == m_prev_l);
        if (!eq) m_match = 0;
        else if (m_match < LOCK) m_match++;
        m_have_prev = 1'b1;
        m_prev_h    = h;
        m_prev_l    = l;
        e.h   = h;
        e.l   = l;
        e.lk  = (m_match == LOCK);
        e.gap = m_first ? 0 : h + l;
        m_first = 1'b0;
        sb.push_back(e);
    endtask

    task automatic run_period(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
        expect_period(h, l);
    endtask

    task automatic model_reset();
        m_have_prev = 1'b0;
        m_match     = 0;
        m_first     = 1'b1;
    endtask

    task automatic start_meas();
        sig_in = 1'b0;
        tick(3);
        model_reset();
        enable = 1'b1;
        tick(4);
    endtask

    task automatic finish_meas(input string name);
        drive(1'b1, 1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        enable = 1'b0;
        tick(1);
        sig_in = 1'b0;
        tick(4);
    endtask

    task automatic monitor();
        int  cyc     = 0;
        int  last_pv = 0;
        bit  pv_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (pv === 1'b1) begin
                checks++;
                if (pv_prev) begin
                    errors++;
                    $display("FAIL pulse_width: period_valid high %0d cycles in a row, required 1", 2);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got period_valid with hi=%0d lo=%0d, none expected", hpc, lpc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (hpc !== 16'(e.h)) begin
                        errors++;
                        $display("FAIL high_phase: got %0d required %0d", hpc, e.h);
                    end
                    checks++;
                    if (lpc !== 16'(e.l)) begin
                        errors++;
                        $display("FAIL low_phase: got %0d required %0d", lpc, e.l);
                    end
                    checks++;
                    if (lk !== e.lk) begin
                        errors++;
                        $display("FAIL locked: got %0b required %0b (pair %0d/%0d)", lk, e.lk, e.h, e.l);
                    end
                    if (e.gap != 0) begin
                        checks++;
                        if (cyc - last_pv != e.gap) begin
                            errors++;
                            $display("FAIL valid_spacing: got %0d cycles required %0d", cyc - last_pv, e.gap);
                        end
                    end
                end
                last_pv = cyc;
            end
            pv_prev = (pv === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; en_t = 1'b0;
        sig_in = 1'b0; sig_t = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sig_in = ~sig_in; sig_t = ~sig_t;
            tick(1);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig_in = 1'($urandom_range(0, 1));
            sig_t  = sig_in;
            tick(1);
        end
        checks++; if (hpc !== 16'd0) begin errors++; $display("FAIL reset_high: got %0d required 0", hpc); end
        checks++; if (lpc !== 16'd0) begin errors++; $display("FAIL reset_low: got %0d required 0", lpc); end
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", pv); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b required 0", lk); end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b required 0", to); end
        checks++; if ({hpc_t, lpc_t, pv_t, lk_t, to_t} !== 11'd0) begin
            errors++; $display("FAIL reset_small: got %h required 0", {hpc_t, lpc_t, pv_t, lk_t, to_t});
        end
        sig_in = 1'b0; sig_t = 1'b0;
        tick(4);
    endtask

    task automatic test_basic_lock();
        start_meas();
        for (int i = 0; i < 6; i++) run_period(3, 5);
        for (int i = 0; i < 6; i++) run_period(4, 5);
        finish_meas("basic_lock");
    endtask

    task automatic test_min_phase();
        start_meas();
        for (int i = 0; i < 7; i++) run_period(1, 1);
        finish_meas("min_phase");
    endtask

    task automatic test_patterns();
        start_meas();
        run_period(2, 7);
        run_period(6, 1);
        run_period(5, 5);
        run_period(5, 5);
        run_period(1, 9);
        finish_meas("patterns");
    endtask

    task automatic test_enable_mid();
        start_meas();
        for (int i = 0; i < 5; i++) run_period(2, 3);
        drive(1'b1, 5);
        enable = 1'b0;
        tick(3);
        checks++; if (hpc !== 16'd2) begin errors++; $display("FAIL hold_high: got %0d required 2", hpc); end
        checks++; if (lpc !== 16'd3) begin errors++; $display("FAIL hold_low: got %0d required 3", lpc); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL idle_locked: got %0b required 0", lk); end
        checks++; if (sb.size() != 0) begin
            errors++; $display("FAIL idle_pending: got %0d pending required 0", sb.size()); sb.delete();
        end
        model_reset();
        enable = 1'b1;
        tick(3);
        drive(1'b0, 3);
        run_period(2, 3);
        finish_meas("enable_mid");
    endtask

    task automatic test_timeout();
        int waited;
        sig_t = 1'b0;
        en_t  = 1'b1;
        tick(3);
        for (int i = 0; i < 6; i++) begin
            sig_t = 1'b1;
            tick(3);
            if (i == 5) begin
                checks++;
                if (lk_t !== 1'b1) begin errors++; $display("FAIL pre_timeout_lock: got %0b required 1", lk_t); end
            end
            sig_t = 1'b0;
            if (i < 5) tick(5);
        end
        tick(20);
        checks++; if (to_t !== 1'b1) begin errors++; $display("FAIL timeout_set: got %0b required 1", to_t); end
        checks++; if (lk_t !== 1'b0) begin errors++; $display("FAIL timeout_unlock: got %0b required 0", lk_t); end
        sig_t  = 1'b1;
        waited = 0;
        while (pv_t !== 1'b1 && waited < 10) begin
            tick(1);
            waited++;
        end
        checks++;
        if (pv_t !== 1'b1) begin
            errors++; $display("FAIL timeout_valid: no period_valid within %0d cycles", waited);
        end else begin
            checks++; if (lpc_t !== 4'd15) begin errors++; $display("FAIL sat_low: got %0d required 15", lpc_t); end
            checks++; if (hpc_t !== 4'd3) begin errors++; $display("FAIL sat_high: got %0d required 3", hpc_t); end
        end
        tick(5);
        checks++; if (to_t !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b required 1", to_t); end
        en_t = 1'b0;
        tick(2);
        checks++; if (to_t !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b required 0", to_t); end
        checks++; if (lpc_t !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d required 15", lpc_t); end
        sig_t = 1'b0;
        tick(4);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic_lock();
        test_min_phase();
        test_patterns();
        test_enable_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
